// File: rtl/game_over_banner_ctrl_if.sv
// rtl/game_over_banner_ctrl_if.sv - match-end controller signal bundle (game events in, banner/score out)
interface game_over_banner_ctrl_if #(
  parameter int posBits    = 9,
  parameter int SCORE_BITS = 3
);
  logic                  frame_tick;
  logic                  goal_p1;
  logic                  goal_p2;
  logic                  restart;
  logic [SCORE_BITS-1:0] score1;
  logic [SCORE_BITS-1:0] score2;
  logic                  player;
  logic [posBits-1:0]    banner_x;
  logic [posBits-1:0]    banner_y;
  logic                  banner_visible;
  logic                  game_active;

  // Game side: produces frame/goal/restart events, consumes banner and score state.
  modport master (
    output frame_tick, goal_p1, goal_p2, restart,
    input  score1, score2, player, banner_x, banner_y, banner_visible, game_active
  );

  // Controller side.
  modport slave (
    input  frame_tick, goal_p1, goal_p2, restart,
    output score1, score2, player, banner_x, banner_y, banner_visible, game_active
  );
endinterface

// File: rtl/game_over_banner_ctrl.sv
// rtl/game_over_banner_ctrl.sv - score keeping, winner latch and slide-in banner control; optional blink via BANNER_BLINK_EN
module game_over_banner_ctrl #(
  parameter int posBits      = 9,
  parameter int SCORE_BITS   = 3,
  parameter int WIN_SCORE    = 5,
  parameter int START_Y      = 0,
  parameter int TARGET_Y     = 100,
  parameter int BANNER_X     = 120,
  parameter int STEP         = 2,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  game_over_banner_ctrl_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [SCORE_BITS-1:0] WIN      = SCORE_BITS'(WIN_SCORE);
  localparam logic [posBits-1:0]    Y_START  = posBits'(START_Y);
  localparam logic [posBits-1:0]    Y_TARGET = posBits'(TARGET_Y);
  localparam logic [posBits:0]      Y_TGT_X  = (posBits + 1)'(TARGET_Y);
  localparam logic [posBits:0]      Y_STEP_X = (posBits + 1)'(STEP);
  localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(HOLD_FRAMES);
`ifdef BANNER_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
`endif

  typedef enum logic [1:0] {PLAY, SLIDE, SHOW, WAIT_RELEASE} state_t;

  state_t                state, state_n;
  logic [SCORE_BITS-1:0] score1, score1_n, score2, score2_n;
  logic                  player, player_n;
  logic [posBits-1:0]    banner_y, banner_y_n;
  logic                  visible, visible_n;
  logic                  active, active_n;
  logic [HOLD_W-1:0]     hold, hold_n;
  logic [posBits:0]      y_sum;
`ifdef BANNER_BLINK_EN
  logic [BLINK_W-1:0]    blink, blink_n;
  logic                  blink_adv;
`endif

  // State and every output are registered; reset restores the start-of-match picture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PLAY;
      score1   <= '0;
      score2   <= '0;
      player   <= 1'b0;
      banner_y <= Y_START;
      visible  <= 1'b0;
      active   <= 1'b1;
      hold     <= '0;
`ifdef BANNER_BLINK_EN
      blink    <= '0;
`endif
    end else begin
      state    <= state_n;
      score1   <= score1_n;
      score2   <= score2_n;
      player   <= player_n;
      banner_y <= banner_y_n;
      visible  <= visible_n;
      active   <= active_n;
      hold     <= hold_n;
`ifdef BANNER_BLINK_EN
      blink    <= blink_n;
`endif
    end
  end

  // Next-state logic: scoring in PLAY, slide on frame ticks, hold then two-step restart.
  always_comb begin
    state_n    = state;
    score1_n   = score1;
    score2_n   = score2;
    player_n   = player;
    banner_y_n = banner_y;
    visible_n  = visible;
    active_n   = active;
    hold_n     = hold;
    y_sum      = {1'b0, banner_y} + Y_STEP_X;  // one extra bit so the add cannot wrap
`ifdef BANNER_BLINK_EN
    blink_n    = blink;
    blink_adv  = 1'b0;
`endif
    case (state)
      PLAY: begin
        if (bus.goal_p1 && score1 != WIN) score1_n = score1 + 1'b1;
        if (bus.goal_p2 && score2 != WIN) score2_n = score2 + 1'b1;
        if ((bus.goal_p1 && score1_n == WIN) || (bus.goal_p2 && score2_n == WIN)) begin
          // P1 takes precedence when both reach the winning score together.
          player_n   = bus.goal_p1 && (score1_n == WIN);
          banner_y_n = Y_START;
          visible_n  = 1'b1;
          active_n   = 1'b0;
          state_n    = SLIDE;
        end
      end
      SLIDE: begin
        if (bus.frame_tick) begin
          if (y_sum >= Y_TGT_X) begin
            banner_y_n = Y_TARGET;
            hold_n     = '0;
            visible_n  = 1'b1;
`ifdef BANNER_BLINK_EN
            blink_n    = '0;
`endif
            state_n    = SHOW;
          end else begin
            banner_y_n = y_sum[posBits-1:0];
          end
        end
      end
      SHOW: begin
        // A restart transition swallows any coincident frame tick.
        if (hold == HOLD_MAX && bus.restart) begin
          state_n = WAIT_RELEASE;
        end else if (bus.frame_tick) begin
          if (hold != HOLD_MAX) hold_n = hold + 1'b1;
`ifdef BANNER_BLINK_EN
          blink_adv = 1'b1;
`endif
        end
      end
      default: begin  // WAIT_RELEASE: the button must be let go before a new match starts
        if (!bus.restart) begin
          score1_n   = '0;
          score2_n   = '0;
          visible_n  = 1'b0;
          banner_y_n = Y_START;
          active_n   = 1'b1;
          state_n    = PLAY;
        end else if (bus.frame_tick) begin
`ifdef BANNER_BLINK_EN
          blink_adv = 1'b1;
`endif
        end
      end
    endcase
`ifdef BANNER_BLINK_EN
    if (blink_adv) begin
      if (blink == BLINK_LAST) begin
        blink_n   = '0;
        visible_n = ~visible;
      end else begin
        blink_n = blink + 1'b1;
      end
    end
`endif
  end

  assign bus.score1         = score1;
  assign bus.score2         = score2;
  assign bus.player         = player;
  assign bus.banner_x       = posBits'(BANNER_X);
  assign bus.banner_y       = banner_y;
  assign bus.banner_visible = visible;
  assign bus.game_active    = active;

endmodule
